// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encodings, control-bundle
// bit positions of the memory flags, and the flag-priority helper.
package mem_stage_pkg;

  localparam int unsigned CTRL_W = 33;

  // Bit positions of the memory flags inside the 33-bit control bundle.
  localparam int unsigned MEM_READ_B_BIT  = 8;
  localparam int unsigned MEM_READ_W_BIT  = 9;
  localparam int unsigned MEM_WRITE_B_BIT = 10;
  localparam int unsigned MEM_WRITE_W_BIT = 11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBeat0 = 2'd1,
    StBeat1 = 2'd2,
    StDone  = 2'd3
  } state_t;

  typedef struct packed {
    logic read;
    logic write;
    logic word;
  } access_t;

  // Read wins over write, word wins over byte; a write paired with a read is dropped.
  function automatic access_t resolve_access(input logic read_b, input logic read_w,
                                             input logic write_b, input logic write_w);
    access_t acc;
    acc.read  = read_b | read_w;
    acc.write = ~acc.read & (write_b | write_w);
    acc.word  = acc.read ? read_w : write_w;
    return acc;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Control-bundle field extraction: exposes the memory flags and passes the
// bundle through so downstream logic latches exactly what was decoded.
module ctrl_decode
  import mem_stage_pkg::*;
(
  input  logic [CTRL_W-1:0] control_signals,
  output logic [CTRL_W-1:0] bundle,
  output logic              mem_read_b,
  output logic              mem_read_w,
  output logic              mem_write_b,
  output logic              mem_write_w
);

  assign bundle      = control_signals;
  assign mem_read_b  = control_signals[MEM_READ_B_BIT];
  assign mem_read_w  = control_signals[MEM_READ_W_BIT];
  assign mem_write_b = control_signals[MEM_WRITE_B_BIT];
  assign mem_write_w = control_signals[MEM_WRITE_W_BIT];

endmodule

// File: rtl/mem_stage_watchdog.sv
// Per-beat bus timeout counter. Counts cycles of bus_req without bus_ack and
// flags the cycle in which the TIMEOUT_CYCLES-th unanswered cycle occurs.
module mem_stage_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_req,
  input  logic bus_ack,
  output logic timeout
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;

  // Counter is held at zero while req is low, so it starts from zero on each rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (!bus_req || bus_ack) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout = bus_req && !bus_ack && (cnt_q == LastCount);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: runs byte/word loads and stores over an 8-bit req/ack
// bus and forwards the instruction's control bundle, pc and imm.
// Optional bus timeout with sticky fault flag: define MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CTRL_W-1:0] control_signals_in,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       imm_in,
  input  logic [15:0]       addr_in,
  input  logic [15:0]       wdata_in,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [15:0]       bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata,
  output logic [15:0]       rdata_out,
  output logic              rdata_valid,
  output logic [CTRL_W-1:0] control_signals_out,
  output logic [15:0]       pc_out,
  output logic [15:0]       imm_out
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic              fault
`endif
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t state_q, state_d;

  logic [CTRL_W-1:0] dec_bundle;
  logic              dec_read_b, dec_read_w, dec_write_b, dec_write_w;
  access_t           acc;

  logic [CTRL_W-1:0] ctrl_q;
  logic [15:0]       pc_q, imm_q, addr_q, wdata_q;
  logic              read_q, write_q, word_q;
  logic              gap_q;
  logic [7:0]        lo_q;

  logic              accept, is_mem, beat_ack, timeout, finish;
  logic [15:0]       load_result;

  ctrl_decode u_ctrl_decode (
    .control_signals (control_signals_in),
    .bundle          (dec_bundle),
    .mem_read_b      (dec_read_b),
    .mem_read_w      (dec_read_w),
    .mem_write_b     (dec_write_b),
    .mem_write_w     (dec_write_w)
  );

  assign acc      = resolve_access(dec_read_b, dec_read_w, dec_write_b, dec_write_w);
  assign is_mem   = acc.read | acc.write;
  assign accept   = (state_q == StIdle) && en;
  assign beat_ack = bus_req && bus_ack;
  assign busy     = (state_q != StIdle);

`ifdef MEM_STAGE_TIMEOUT_EN
  mem_stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .bus_req (bus_req),
    .bus_ack (bus_ack),
    .timeout (timeout)
  );

  // Sticky fault: once a beat times out it stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (timeout) begin
      fault <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one beat for byte access, two for word; timeout skips to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en && is_mem) state_d = StBeat0;
      StBeat0: begin
        if (beat_ack) begin
          state_d = word_q ? StBeat1 : StDone;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StBeat1: if (beat_ack || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs decoded from state; the first BEAT1 cycle is the req-low gap.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = addr_q;
    bus_wdata = wdata_q[7:0];
    unique case (state_q)
      StBeat0: begin
        bus_req = 1'b1;
        bus_we  = write_q;
      end
      StBeat1: begin
        bus_req   = ~gap_q;
        bus_we    = write_q & ~gap_q;
        bus_addr  = addr_q + 16'd1;
        bus_wdata = wdata_q[15:8];
      end
      default: ;
    endcase
  end

  // Latch the instruction whenever the stage accepts one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      pc_q    <= 16'd0;
      imm_q   <= 16'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      word_q  <= 1'b0;
    end else if (accept) begin
      ctrl_q  <= dec_bundle;
      pc_q    <= pc_in;
      imm_q   <= imm_in;
      addr_q  <= addr_in;
      wdata_q <= wdata_in;
      read_q  <= acc.read;
      write_q <= acc.write;
      word_q  <= acc.word;
    end
  end

  // Inter-beat gap marker and low-byte capture of a word load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= 1'b0;
      lo_q  <= 8'd0;
    end else begin
      gap_q <= (state_q == StBeat0) && beat_ack && word_q;
      if ((state_q == StBeat0) && beat_ack && read_q) begin
        lo_q <= bus_rdata;
      end
    end
  end

  assign finish = (state_q != StDone) && (state_d == StDone);

  always_comb begin
    if (timeout) begin
      load_result = 16'hFFFF;
    end else if (word_q) begin
      load_result = {bus_rdata, lo_q};
    end else begin
      load_result = {8'h00, bus_rdata};
    end
  end

  // Forwarded outputs: pass-through for non-memory ops, loaded on entry to DONE otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      control_signals_out <= '0;
      pc_out              <= 16'd0;
      imm_out             <= 16'd0;
      rdata_out           <= 16'd0;
      rdata_valid         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      if (accept && !is_mem) begin
        control_signals_out <= dec_bundle;
        pc_out              <= pc_in;
        imm_out             <= imm_in;
      end else if (finish) begin
        control_signals_out <= ctrl_q;
        pc_out              <= pc_q;
        imm_out             <= imm_q;
        if (read_q) begin
          rdata_valid <= 1'b1;
          rdata_out   <= load_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model of the expected
// bus beats and forwarded results, checked against the DUT every cycle.
module tb_mem_stage;
  import mem_stage_pkg::*;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
  localparam bit          TO_EN      = 1'b1;
`else
  localparam int unsigned TB_TIMEOUT = 255;
  localparam bit          TO_EN      = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } beat_t;

  logic              clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic [15:0]       pc_in = 16'd0, imm_in = 16'd0, addr_in = 16'd0, wdata_in = 16'd0;
  logic              busy, bus_req, bus_we, bus_ack = 1'b0, rdata_valid;
  logic [15:0]       bus_addr, rdata_out, pc_out, imm_out;
  logic [7:0]        bus_wdata, bus_rdata = 8'd0;
  logic [CTRL_W-1:0] ctrl_out;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic              fault;
`endif

  mem_stage #(
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .control_signals_in  (ctrl_in),
    .pc_in               (pc_in),
    .imm_in              (imm_in),
    .addr_in             (addr_in),
    .wdata_in            (wdata_in),
    .busy                (busy),
    .bus_req             (bus_req),
    .bus_we              (bus_we),
    .bus_addr            (bus_addr),
    .bus_wdata           (bus_wdata),
    .bus_ack             (bus_ack),
    .bus_rdata           (bus_rdata),
    .rdata_out           (rdata_out),
    .rdata_valid         (rdata_valid),
    .control_signals_out (ctrl_out),
    .pc_out              (pc_out),
    .imm_out             (imm_out)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .fault               (fault)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: expected outputs and the in-flight transaction.
  bit                m_busy, m_valid, m_done, m_gap, m_read, m_word, m_fault;
  logic [15:0]       m_pc, m_imm, m_rdata;
  logic [CTRL_W-1:0] m_ctrl;
  logic [15:0]       t_pc, t_imm;
  logic [CTRL_W-1:0] t_ctrl;
  logic [7:0]        m_lo, m_hi;
  int                beat_idx, wait_left, req_cycles;
  beat_t             beat_q[$];

  // Stimulus controls.
  bit                have_req, junk, no_ack;
  int                forced_wait = -1;
  logic [7:0]        rbytes[$];
  logic [CTRL_W-1:0] r_ctrl;
  logic [15:0]       r_pc, r_imm, r_addr, r_wdata;

  // Observations of the DUT within one transaction.
  beat_t             log_q[$];
  int                valid_seen, req_seen, busy_seen;
  bit                chk_beat1_req;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick_wait();
    return (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [7:0] next_byte();
    if (rbytes.size() != 0) return rbytes.pop_front();
    return 8'($urandom);
  endfunction

  function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [3:0] flags);
    logic [CTRL_W-1:0] c;
    c = {1'($urandom), 32'($urandom)};
    c[MEM_READ_B_BIT]  = flags[0];
    c[MEM_READ_W_BIT]  = flags[1];
    c[MEM_WRITE_B_BIT] = flags[2];
    c[MEM_WRITE_W_BIT] = flags[3];
    return c;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_done = 0; m_gap = 0; m_read = 0; m_word = 0; m_fault = 0;
    m_pc = 0; m_imm = 0; m_rdata = 0; m_ctrl = '0;
    beat_q.delete();
  endtask

  task automatic finish_txn(input bit timed_out);
    m_done = 1;
    m_pc   = t_pc;
    m_imm  = t_imm;
    m_ctrl = t_ctrl;
    if (m_read) begin
      m_valid = 1;
      if (timed_out)   m_rdata = 16'hFFFF;
      else if (m_word) m_rdata = {m_hi, m_lo};
      else             m_rdata = {8'h00, m_lo};
    end
  endtask

  // Advance the model across the coming clock edge, given the inputs just driven.
  task automatic model_update();
    bit rd, wr, wd;
    m_valid = 0;
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (en) begin
        rd = ctrl_in[MEM_READ_B_BIT] | ctrl_in[MEM_READ_W_BIT];
        wr = !rd && (ctrl_in[MEM_WRITE_B_BIT] | ctrl_in[MEM_WRITE_W_BIT]);
        wd = rd ? ctrl_in[MEM_READ_W_BIT] : ctrl_in[MEM_WRITE_W_BIT];
        if (!rd && !wr) begin
          m_pc = pc_in; m_imm = imm_in; m_ctrl = ctrl_in;
        end else begin
          m_busy = 1; m_read = rd; m_word = wd;
          t_pc = pc_in; t_imm = imm_in; t_ctrl = ctrl_in;
          beat_q.push_back('{addr: addr_in, we: wr, wdata: wdata_in[7:0]});
          if (wd) beat_q.push_back('{addr: addr_in + 16'd1, we: wr, wdata: wdata_in[15:8]});
          beat_idx = 0; m_gap = 0; wait_left = pick_wait(); req_cycles = 0;
        end
      end
    end else if (m_gap) begin
      m_gap = 0; wait_left = pick_wait(); req_cycles = 0;
    end else if (bus_ack) begin
      if (m_read) begin
        if (beat_idx == 0) m_lo = bus_rdata;
        else               m_hi = bus_rdata;
      end
      void'(beat_q.pop_front());
      beat_idx++;
      if (beat_q.size() == 0) finish_txn(1'b0);
      else                    m_gap = 1;
    end else begin
      req_cycles++;
      if (TO_EN && req_cycles == int'(TB_TIMEOUT)) begin
        beat_q.delete();
        m_fault = 1;
        finish_txn(1'b1);
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
  endtask

  // One cycle: compare at the falling edge, then drive inputs and step the model.
  task automatic step();
    bit exp_req;
    @(negedge clk);
    exp_req = m_busy && !m_done && !m_gap && (beat_q.size() != 0);
    chk("busy", 33'(busy), 33'(m_busy));
    chk("rdata_valid", 33'(rdata_valid), 33'(m_valid));
    chk("bus_req", 33'(bus_req), 33'(exp_req));
    chk("pc_out", 33'(pc_out), 33'(m_pc));
    chk("imm_out", 33'(imm_out), 33'(m_imm));
    chk("ctrl_out", ctrl_out, m_ctrl);
    chk("rdata_out", 33'(rdata_out), 33'(m_rdata));
`ifdef MEM_STAGE_TIMEOUT_EN
    chk("fault", 33'(fault), 33'(m_fault));
`endif
    if (exp_req) begin
      chk("bus_addr", 33'(bus_addr), 33'(beat_q[0].addr));
      chk("bus_we", 33'(bus_we), 33'(beat_q[0].we));
      chk("bus_wdata", 33'(bus_wdata), 33'(beat_q[0].wdata));
    end
    chk_beat1_req = exp_req && (beat_idx == 1);
    if (rdata_valid) valid_seen++;
    if (bus_req) req_seen++;
    if (busy) busy_seen++;

    if (!m_busy && have_req) begin
      en = 1; ctrl_in = r_ctrl; pc_in = r_pc; imm_in = r_imm; addr_in = r_addr;
      wdata_in = r_wdata; have_req = 0;
    end else if (m_busy && junk) begin
      en = 1'($urandom); ctrl_in = mk_ctrl(4'($urandom)); pc_in = 16'($urandom);
      imm_in = 16'($urandom); addr_in = 16'($urandom); wdata_in = 16'($urandom);
    end else begin
      en = 0;
    end
    if (exp_req) begin
      bus_ack   = !no_ack && (wait_left == 0);
      bus_rdata = bus_ack ? next_byte() : 8'($urandom);
      if (bus_ack) log_q.push_back('{addr: bus_addr, we: bus_we, wdata: bus_wdata});
    end else begin
      bus_ack   = junk ? 1'($urandom) : 1'b0;
      bus_rdata = 8'($urandom);
    end
    model_update();
  endtask

  task automatic run_txn(input logic [CTRL_W-1:0] c, input logic [15:0] pc,
                         input logic [15:0] imm, input logic [15:0] addr,
                         input logic [15:0] wdata);
    int n;
    r_ctrl = c; r_pc = pc; r_imm = imm; r_addr = addr; r_wdata = wdata;
    have_req = 1;
    log_q.delete(); valid_seen = 0; req_seen = 0; busy_seen = 0;
    n = 0;
    while (have_req && n < 50) begin step(); n++; end
    n = 0;
    while (m_busy && n < 300) begin step(); n++; end
    if (m_busy || have_req) chk("txn_bound", 33'd1, 33'd0);
    step();
  endtask

  initial begin
    int n;
    model_reset();
    #1;
    chk("rst_bus_req", 33'(bus_req), 33'd0);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_bus_addr", 33'(bus_addr), 33'd0);
    chk("rst_bus_wdata", 33'(bus_wdata), 33'd0);
    chk("rst_rdata_out", 33'(rdata_out), 33'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Non-memory op: single-cycle pass-through.
    run_txn(mk_ctrl(4'b0000), 16'h0040, 16'h0007, 16'h2222, 16'h3333);
    chk("lit_nonmem_pc", 33'(pc_out), 33'h0040);
    chk("lit_nonmem_req", 33'(req_seen), 33'd0);
    chk("lit_nonmem_busy", 33'(busy_seen), 33'd0);

    // Byte load, two wait cycles, data A5.
    forced_wait = 2;
    rbytes.push_back(8'hA5);
    run_txn(mk_ctrl(4'b0001), 16'h0100, 16'h0001, 16'h1234, 16'h0000);
    chk("lit_bload_rdata", 33'(rdata_out), 33'h00A5);
    chk("lit_bload_pulses", 33'(valid_seen), 33'd1);
    chk("lit_bload_beats", 33'(log_q.size()), 33'd1);
    if (log_q.size() >= 1) chk("lit_bload_addr", 33'(log_q[0].addr), 33'h1234);

    // Word load at FFFF: second beat wraps to 0000.
    forced_wait = 0;
    rbytes.push_back(8'h34);
    rbytes.push_back(8'h12);
    run_txn(mk_ctrl(4'b0010), 16'h0102, 16'h0002, 16'hFFFF, 16'h0000);
    chk("lit_wload_rdata", 33'(rdata_out), 33'h1234);
    chk("lit_wload_beats", 33'(log_q.size()), 33'd2);
    if (log_q.size() >= 2) chk("lit_wload_addr1", 33'(log_q[1].addr), 33'h0000);

    // Word store BEEF at 0100, with a read flag absent.
    forced_wait = 1;
    run_txn(mk_ctrl(4'b1000), 16'h0104, 16'h0003, 16'h0100, 16'hBEEF);
    chk("lit_wstore_pulses", 33'(valid_seen), 33'd0);
    chk("lit_wstore_beats", 33'(log_q.size()), 33'd2);
    if (log_q.size() >= 2) begin
      chk("lit_wstore_b0", {9'd0, log_q[0].addr, log_q[0].we, log_q[0].wdata},
          {9'd0, 16'h0100, 1'b1, 8'hEF});
      chk("lit_wstore_b1", {9'd0, log_q[1].addr, log_q[1].we, log_q[1].wdata},
          {9'd0, 16'h0101, 1'b1, 8'hBE});
    end

    // Read and write flags together: the write is dropped, a word read occurs.
    forced_wait = 0;
    rbytes.push_back(8'h5A);
    rbytes.push_back(8'hC3);
    run_txn(mk_ctrl(4'b1010), 16'h0106, 16'h0004, 16'h0200, 16'h1111);
    chk("lit_rw_rdata", 33'(rdata_out), 33'hC35A);
    if (log_q.size() >= 1) chk("lit_rw_we", 33'(log_q[0].we), 33'd0);

    // Junk en/ack while busy, then reset in the middle of BEAT1.
    junk = 1;
    forced_wait = 3;
    r_ctrl = mk_ctrl(4'b0010); r_pc = 16'h0300; r_imm = 16'h0; r_addr = 16'h4000;
    r_wdata = 16'h0;
    have_req = 1;
    n = 0;
    chk_beat1_req = 0;
    while (!chk_beat1_req && n < 100) begin step(); n++; end
    chk("reach_beat1", 33'(chk_beat1_req), 33'd1);
    #1 rst = 1;
    #1;
    chk("midrst_bus_req", 33'(bus_req), 33'd0);
    chk("midrst_busy", 33'(busy), 33'd0);
    chk("midrst_valid", 33'(rdata_valid), 33'd0);
    model_reset();
    @(negedge clk);
    rst = 0; en = 0; bus_ack = 0;
    forced_wait = 1;
    rbytes.delete();
    rbytes.push_back(8'h6B);
    run_txn(mk_ctrl(4'b0001), 16'h0302, 16'h0009, 16'h0042, 16'h0000);
    chk("lit_post_rst_rdata", 33'(rdata_out), 33'h006B);
    chk("lit_post_rst_pc", 33'(pc_out), 33'h0302);

`ifdef MEM_STAGE_TIMEOUT_EN
    // Word load never acknowledged: four req cycles, fault, FFFF, no second beat.
    junk = 0;
    no_ack = 1;
    run_txn(mk_ctrl(4'b0010), 16'h0500, 16'h0000, 16'h0600, 16'h0000);
    no_ack = 0;
    chk("lit_to_req_cycles", 33'(req_seen), 33'd4);
    chk("lit_to_fault", 33'(fault), 33'd1);
    chk("lit_to_rdata", 33'(rdata_out), 33'hFFFF);
    chk("lit_to_pulses", 33'(valid_seen), 33'd1);
    junk = 1;
`endif

    // Randomized traffic against the model.
    forced_wait = -1;
    for (int i = 0; i < 120; i++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      run_txn(mk_ctrl(fl), 16'($urandom), 16'($urandom),
              ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
